fp_issue_ctrl: RTL and testbench

FP_ISSUE_CTRL -- requirements
Module: fp_issue_ctrl

---
 rtl/fp_issue_ctrl_pkg.sv | 20 ++
 rtl/fp_issue_ctrl_if.sv | 33 +++
 rtl/fp_issue_ctrl_scoreboard.sv | 31 +++
 rtl/fp_issue_ctrl.sv | 102 ++++++++++
 tb/tb_fp_issue_ctrl.sv | 193 +++++++++++++++++++
 5 files changed

// File: rtl/fp_issue_ctrl_pkg.sv
// Shared FP issue definitions: default latency, register index width, tag and state types.
package wi23_defs;

  localparam int unsigned FP_LAT_DEF = 2;
  localparam int unsigned NREGS_DEF  = 32;
  localparam int unsigned REG_IDX_W  = $clog2(NREGS_DEF);

  typedef struct packed {
    logic                 valid;
    logic                 wr_en;
    logic [REG_IDX_W-1:0] rd;
  } fp_tag_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_EXEC  = 2'd1,
    ST_FLUSH = 2'd2
  } fp_state_e;

endpackage

// File: rtl/fp_issue_ctrl_if.sv
// Issue/execute/writeback bundle between decode, the FP issue controller and the FP unit.
interface fp_issue_if #(parameter int unsigned NREGS = 32);

  localparam int unsigned RW = $clog2(NREGS);

  logic             iss_valid;
  logic             iss_ready;
  logic [RW-1:0]    iss_rd;
  logic [RW-1:0]    iss_rs1;
  logic [RW-1:0]    iss_rs2;
  logic             iss_use_rs2;
  logic             iss_wr_en;
  logic             flush;
  logic             fex_valid;
  logic             fex_err;
  logic             wb_valid;
  logic [RW-1:0]    wb_rd;
  logic             wb_err;
  logic [NREGS-1:0] sb_busy;
  logic             busy;
  logic             busy_er;

  modport master (
    output iss_valid, iss_rd, iss_rs1, iss_rs2, iss_use_rs2, iss_wr_en, flush, fex_err,
    input  iss_ready, fex_valid, wb_valid, wb_rd, wb_err, sb_busy, busy, busy_er
  );

  modport slave (
    input  iss_valid, iss_rd, iss_rs1, iss_rs2, iss_use_rs2, iss_wr_en, flush, fex_err,
    output iss_ready, fex_valid, wb_valid, wb_rd, wb_err, sb_busy, busy, busy_er
  );

endinterface

// File: rtl/fp_issue_ctrl_scoreboard.sv
// Pending-write scoreboard for FP registers; a same-cycle set wins over clear.
module fp_scoreboard #(
  parameter int unsigned NREGS = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     set_en_i,
  input  logic [$clog2(NREGS)-1:0] set_idx_i,
  input  logic                     clr_en_i,
  input  logic [$clog2(NREGS)-1:0] clr_idx_i,
  input  logic                     flush_i,
  output logic [NREGS-1:0]         busy_o
);

  logic [NREGS-1:0] busy_q, busy_d;

  always_comb begin
    busy_d = busy_q;
    if (clr_en_i) busy_d[clr_idx_i] = 1'b0;
    if (set_en_i) busy_d[set_idx_i] = 1'b1;
    if (flush_i)  busy_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy_q <= '0;
    else        busy_q <= busy_d;
  end

  assign busy_o = busy_q;

endmodule

// File: rtl/fp_issue_ctrl.sv
// FP issue controller: hazard-checked issue, latency tag pipeline, writeback and flush.
// Define FP_ISSUE_PIPELINED_EN to allow one issue per cycle regardless of ops in flight.
module fp_issue_ctrl
  import wi23_defs::*;
#(
  parameter int unsigned FP_LAT = FP_LAT_DEF,
  parameter int unsigned NREGS  = NREGS_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  fp_issue_if.slave   bus
);

  localparam int unsigned DEPTH = FP_LAT - 1;
  localparam int unsigned RW    = $clog2(NREGS);

  fp_state_e        state_q, state_d;
  fp_tag_t          tags_q [DEPTH];
  fp_tag_t          tags_d [DEPTH];
  fp_tag_t          last_c;
  logic [NREGS-1:0] sb_busy;
  logic             older_valid_c, any_valid_c, busy_er_c;
  logic             hazard_c, occupied_c, ready_c, fire_c, wb_valid_c;

  // Stage occupancy; older_valid_c covers every stage except the writeback one.
  always_comb begin
    last_c        = tags_q[DEPTH-1];
    older_valid_c = 1'b0;
    for (int i = 0; i < int'(DEPTH) - 1; i++) older_valid_c = older_valid_c | tags_q[i].valid;
    any_valid_c   = older_valid_c | last_c.valid;
    busy_er_c     = last_c.valid & ~older_valid_c;
  end

  always_comb begin
    hazard_c = sb_busy[bus.iss_rs1]
             | (bus.iss_use_rs2 & sb_busy[bus.iss_rs2])
             | (bus.iss_wr_en & sb_busy[bus.iss_rd]);
`ifdef FP_ISSUE_PIPELINED_EN
    occupied_c = 1'b0;
`else
    occupied_c = any_valid_c & ~busy_er_c;
`endif
    ready_c    = rst_n & ~bus.flush & (state_q != ST_FLUSH) & ~hazard_c & ~occupied_c;
    fire_c     = bus.iss_valid & ready_c;
    wb_valid_c = last_c.valid & last_c.wr_en & ~bus.flush;
  end

  // Next state and tag shift.
  always_comb begin
    state_d = state_q;
    tags_d[0] = '0;
    if (fire_c) begin
      tags_d[0].valid = 1'b1;
      tags_d[0].wr_en = bus.iss_wr_en;
      tags_d[0].rd    = REG_IDX_W'(bus.iss_rd);
    end
    for (int i = 1; i < int'(DEPTH); i++) tags_d[i] = tags_q[i-1];

    case (state_q)
      ST_IDLE:  if (fire_c) state_d = ST_EXEC;
      ST_EXEC:  if (!fire_c && !older_valid_c) state_d = ST_IDLE;
      ST_FLUSH: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase

    if (bus.flush) begin
      state_d = ST_FLUSH;
      for (int i = 0; i < int'(DEPTH); i++) tags_d[i] = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      for (int i = 0; i < int'(DEPTH); i++) tags_q[i] <= '0;
    end else begin
      state_q <= state_d;
      for (int i = 0; i < int'(DEPTH); i++) tags_q[i] <= tags_d[i];
    end
  end

  fp_scoreboard #(.NREGS(NREGS)) u_sb (
    .clk       (clk),
    .rst_n     (rst_n),
    .set_en_i  (fire_c & bus.iss_wr_en),
    .set_idx_i (bus.iss_rd),
    .clr_en_i  (wb_valid_c),
    .clr_idx_i (RW'(last_c.rd)),
    .flush_i   (bus.flush),
    .busy_o    (sb_busy)
  );

  assign bus.iss_ready = ready_c;
  assign bus.fex_valid = fire_c;
  assign bus.wb_valid  = wb_valid_c;
  assign bus.wb_rd     = wb_valid_c ? RW'(last_c.rd) : '0;
  assign bus.wb_err    = last_c.valid & bus.fex_err;
  assign bus.sb_busy   = sb_busy;
  assign bus.busy      = fire_c | any_valid_c;
  assign bus.busy_er   = busy_er_c;

endmodule

// File: tb/tb_fp_issue_ctrl.sv
// Directed bench for fp_issue_ctrl at FP_LAT=2, NREGS=32.
module tb_fp_issue_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   pass_cnt = 0;
  int   total_cnt = 0;

  always #5 clk = ~clk;

  fp_issue_if #(.NREGS(32)) bus ();

  fp_issue_ctrl #(.FP_LAT(2), .NREGS(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic v, input logic [4:0] rd, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic use2, input logic wr);
    bus.iss_valid   = v;
    bus.iss_rd      = rd;
    bus.iss_rs1     = rs1;
    bus.iss_rs2     = rs2;
    bus.iss_use_rs2 = use2;
    bus.iss_wr_en   = wr;
  endtask

  task automatic idle();
    present(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    present(1'b1, 5'd2, 5'd0, 5'd0, 1'b0, 1'b1);
    #2;
    total_cnt++; if (bus.iss_ready !== 1'b0) $display("FAIL rst_ready got %b exp 0", bus.iss_ready); else pass_cnt++;
    total_cnt++; if (bus.fex_valid !== 1'b0) $display("FAIL rst_fex got %b exp 0", bus.fex_valid); else pass_cnt++;
    total_cnt++; if (bus.sb_busy !== 32'h0) $display("FAIL rst_sb got %h exp 0", bus.sb_busy); else pass_cnt++;
    total_cnt++; if ({bus.wb_valid, bus.wb_err, bus.busy, bus.busy_er} !== 4'b0)
      $display("FAIL rst_flags got %b exp 0000", {bus.wb_valid, bus.wb_err, bus.busy, bus.busy_er}); else pass_cnt++;
    idle();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_single();
    next_cyc(); present(1'b1, 5'd5, 5'd0, 5'd0, 1'b0, 1'b1);
    @(negedge clk);
    total_cnt++; if (bus.fex_valid !== 1'b1) $display("FAIL single_fex got %b exp 1", bus.fex_valid); else pass_cnt++;
    total_cnt++; if (bus.wb_valid !== 1'b0) $display("FAIL single_wb_early got %b exp 0", bus.wb_valid); else pass_cnt++;
    total_cnt++; if (bus.sb_busy !== 32'h0) $display("FAIL single_sb_t got %h exp 0", bus.sb_busy); else pass_cnt++;
    next_cyc(); idle();
    @(negedge clk);
    total_cnt++; if (bus.wb_valid !== 1'b1) $display("FAIL single_wb got %b exp 1", bus.wb_valid); else pass_cnt++;
    total_cnt++; if (bus.wb_rd !== 5'd5) $display("FAIL single_wb_rd got %0d exp 5", bus.wb_rd); else pass_cnt++;
    total_cnt++; if (bus.sb_busy !== 32'h20) $display("FAIL single_sb got %h exp 20", bus.sb_busy); else pass_cnt++;
    total_cnt++; if ({bus.busy, bus.busy_er} !== 2'b11) $display("FAIL single_busy got %b exp 11", {bus.busy, bus.busy_er}); else pass_cnt++;
    next_cyc();
    @(negedge clk);
    total_cnt++; if (bus.wb_valid !== 1'b0) $display("FAIL single_wb_end got %b exp 0", bus.wb_valid); else pass_cnt++;
    total_cnt++; if (bus.sb_busy !== 32'h0) $display("FAIL single_sb_end got %h exp 0", bus.sb_busy); else pass_cnt++;
    total_cnt++; if (bus.busy !== 1'b0) $display("FAIL single_busy_end got %b exp 0", bus.busy); else pass_cnt++;
  endtask

  task automatic test_raw();
    next_cyc(); present(1'b1, 5'd3, 5'd0, 5'd0, 1'b0, 1'b1);
    next_cyc(); present(1'b1, 5'd4, 5'd3, 5'd0, 1'b0, 1'b1);
    @(negedge clk);
    total_cnt++; if (bus.iss_ready !== 1'b0) $display("FAIL raw_stall got %b exp 0", bus.iss_ready); else pass_cnt++;
    next_cyc();
    @(negedge clk);
    total_cnt++; if (bus.fex_valid !== 1'b1) $display("FAIL raw_fire got %b exp 1", bus.fex_valid); else pass_cnt++;
    next_cyc(); idle();
    @(negedge clk);
    total_cnt++; if (bus.wb_rd !== 5'd4) $display("FAIL raw_wb_rd got %0d exp 4", bus.wb_rd); else pass_cnt++;
    next_cyc();
  endtask

  task automatic test_back_to_back();
    next_cyc(); present(1'b1, 5'd1, 5'd0, 5'd0, 1'b0, 1'b1);
    @(negedge clk);
    total_cnt++; if (bus.fex_valid !== 1'b1) $display("FAIL b2b_fire0 got %b exp 1", bus.fex_valid); else pass_cnt++;
    next_cyc(); present(1'b1, 5'd2, 5'd0, 5'd0, 1'b0, 1'b1);
    @(negedge clk);
    total_cnt++; if (bus.fex_valid !== 1'b1) $display("FAIL b2b_fire1 got %b exp 1", bus.fex_valid); else pass_cnt++;
    total_cnt++; if (bus.wb_rd !== 5'd1) $display("FAIL b2b_wb1 got %0d exp 1", bus.wb_rd); else pass_cnt++;
    next_cyc(); idle();
    @(negedge clk);
    total_cnt++; if (bus.wb_rd !== 5'd2) $display("FAIL b2b_wb2 got %0d exp 2", bus.wb_rd); else pass_cnt++;
    total_cnt++; if (bus.sb_busy !== 32'h4) $display("FAIL b2b_sb got %h exp 4", bus.sb_busy); else pass_cnt++;
    next_cyc();
  endtask

  task automatic test_hazards();
    next_cyc(); present(1'b1, 5'd11, 5'd0, 5'd0, 1'b0, 1'b1);
    next_cyc(); present(1'b1, 5'd12, 5'd0, 5'd11, 1'b1, 1'b1);
    #1;
    total_cnt++; if (bus.iss_ready !== 1'b0) $display("FAIL rs2_stall got %b exp 0", bus.iss_ready); else pass_cnt++;
    bus.iss_use_rs2 = 1'b0;
    #1;
    total_cnt++; if (bus.iss_ready !== 1'b1) $display("FAIL rs2_unused got %b exp 1", bus.iss_ready); else pass_cnt++;
    next_cyc(); present(1'b1, 5'd12, 5'd0, 5'd0, 1'b0, 1'b1);
    #1;
    total_cnt++; if (bus.iss_ready !== 1'b0) $display("FAIL waw_stall got %b exp 0", bus.iss_ready); else pass_cnt++;
    total_cnt++; if (bus.wb_rd !== 5'd12) $display("FAIL waw_wb_rd got %0d exp 12", bus.wb_rd); else pass_cnt++;
    bus.iss_wr_en = 1'b0;
    #1;
    total_cnt++; if (bus.iss_ready !== 1'b1) $display("FAIL nowr_ready got %b exp 1", bus.iss_ready); else pass_cnt++;
    next_cyc(); idle();
    @(negedge clk);
    total_cnt++; if (bus.wb_valid !== 1'b0) $display("FAIL nowr_wb got %b exp 0", bus.wb_valid); else pass_cnt++;
    total_cnt++; if ({bus.busy, bus.busy_er} !== 2'b11) $display("FAIL nowr_busy got %b exp 11", {bus.busy, bus.busy_er}); else pass_cnt++;
    total_cnt++; if (bus.sb_busy !== 32'h0) $display("FAIL nowr_sb got %h exp 0", bus.sb_busy); else pass_cnt++;
    next_cyc();
  endtask

  task automatic test_flush();
    next_cyc(); present(1'b1, 5'd7, 5'd0, 5'd0, 1'b0, 1'b1);
    next_cyc(); present(1'b1, 5'd8, 5'd0, 5'd0, 1'b0, 1'b1); bus.flush = 1'b1;
    @(negedge clk);
    total_cnt++; if (bus.iss_ready !== 1'b0) $display("FAIL flush_ready got %b exp 0", bus.iss_ready); else pass_cnt++;
    total_cnt++; if (bus.wb_valid !== 1'b0) $display("FAIL flush_wb got %b exp 0", bus.wb_valid); else pass_cnt++;
    total_cnt++; if (bus.sb_busy !== 32'h80) $display("FAIL flush_sb_t1 got %h exp 80", bus.sb_busy); else pass_cnt++;
    next_cyc(); bus.flush = 1'b0;
    @(negedge clk);
    total_cnt++; if (bus.iss_ready !== 1'b0) $display("FAIL flush_state_ready got %b exp 0", bus.iss_ready); else pass_cnt++;
    total_cnt++; if (bus.sb_busy !== 32'h0) $display("FAIL flush_sb got %h exp 0", bus.sb_busy); else pass_cnt++;
    total_cnt++; if (bus.wb_valid !== 1'b0) $display("FAIL flush_wb2 got %b exp 0", bus.wb_valid); else pass_cnt++;
    next_cyc();
    @(negedge clk);
    total_cnt++; if (bus.iss_ready !== 1'b1) $display("FAIL flush_resume got %b exp 1", bus.iss_ready); else pass_cnt++;
    next_cyc(); idle();
    @(negedge clk);
    total_cnt++; if (bus.wb_rd !== 5'd8) $display("FAIL flush_post_wb got %0d exp 8", bus.wb_rd); else pass_cnt++;
    next_cyc();
  endtask

  task automatic test_err();
    next_cyc(); present(1'b1, 5'd9, 5'd0, 5'd0, 1'b0, 1'b1);
    next_cyc(); idle(); bus.fex_err = 1'b1;
    @(negedge clk);
    total_cnt++; if (bus.wb_err !== 1'b1) $display("FAIL err_wb got %b exp 1", bus.wb_err); else pass_cnt++;
    total_cnt++; if (bus.wb_rd !== 5'd9) $display("FAIL err_wb_rd got %0d exp 9", bus.wb_rd); else pass_cnt++;
    next_cyc();
    @(negedge clk);
    total_cnt++; if (bus.wb_err !== 1'b0) $display("FAIL err_idle got %b exp 0", bus.wb_err); else pass_cnt++;
    bus.fex_err = 1'b0;
  endtask

  task automatic test_reset_mid();
    next_cyc(); present(1'b1, 5'd10, 5'd0, 5'd0, 1'b0, 1'b1);
    next_cyc(); present(1'b1, 5'd13, 5'd0, 5'd0, 1'b0, 1'b1); bus.fex_err = 1'b1;
    rst_n = 1'b0;
    #1;
    total_cnt++; if ({bus.iss_ready, bus.fex_valid, bus.wb_valid, bus.wb_err, bus.busy, bus.busy_er} !== 6'b0)
      $display("FAIL rstmid_flags got %b exp 000000",
               {bus.iss_ready, bus.fex_valid, bus.wb_valid, bus.wb_err, bus.busy, bus.busy_er}); else pass_cnt++;
    total_cnt++; if (bus.wb_rd !== 5'd0) $display("FAIL rstmid_wb_rd got %0d exp 0", bus.wb_rd); else pass_cnt++;
    total_cnt++; if (bus.sb_busy !== 32'h0) $display("FAIL rstmid_sb got %h exp 0", bus.sb_busy); else pass_cnt++;
    next_cyc(); idle(); bus.fex_err = 1'b0; rst_n = 1'b1;
    @(negedge clk);
    total_cnt++; if (bus.wb_valid !== 1'b0) $display("FAIL rstmid_no_wb got %b exp 0", bus.wb_valid); else pass_cnt++;
    next_cyc(); present(1'b1, 5'd14, 5'd0, 5'd0, 1'b0, 1'b1);
    @(negedge clk);
    total_cnt++; if (bus.fex_valid !== 1'b1) $display("FAIL rstmid_refire got %b exp 1", bus.fex_valid); else pass_cnt++;
    next_cyc(); idle();
    @(negedge clk);
    total_cnt++; if (bus.wb_rd !== 5'd14) $display("FAIL rstmid_wb_rd14 got %0d exp 14", bus.wb_rd); else pass_cnt++;
    next_cyc();
  endtask

  initial begin
    bus.flush   = 1'b0;
    bus.fex_err = 1'b0;
    idle();
    test_reset();
    test_single();
    test_raw();
    test_back_to_back();
    test_hazards();
    test_flush();
    test_err();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
